sram_dp_init: RTL and testbench

- Parametrised simple-dual-port synchronous SRAM: one write port, one read port, single clock.
- Successor to the fixed 16x8 single-port array. Adds:
  - generic width and depth
  - per-byte write enables
  - independent read port with registered data and a valid flag
  - write-first bypass
  - hardware clear sequencer that initialises every word after reset or on request
- Used as the local buffer/register-file primitive under FIFOs and packet buffers.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_init_fsm.sv | 95 +++++++++
 rtl/sram_dp_init.sv | 148 ++++++++++++++
 tb/tb_sram_dp_init.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and byte helpers for the simple-dual-port SRAM (sram_dp_init).
// Optional build macro used by the design: SRAM_PARITY_EN.
package sram_pkg;

    // Clear-sequencer states.
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Even parity of one byte: the XOR of its bits.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    // Per-byte merge: take the new byte when its enable is set, else keep the old one.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/sram_init_fsm.sv
// Clear sequencer for sram_dp_init.
// - Holds the state register and the clear counter.
// - Drives INIT_BUSY.
// - Muxes the array write port between the sequencer and the user port.
//   While clearing, user writes and reads are locked out.
module sram_init_fsm #(
    parameter int              AW       = 4,
    parameter int              DW       = 8,
    parameter logic [DW-1:0]   INIT_VAL = {DW{1'b0}}
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              i_init_req,
    input  logic              i_wren,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DW-1:0]     i_wdata,
    input  logic [DW/8-1:0]   i_wbe,
    input  logic              i_pinj,
    input  logic              i_rden,
    output logic              o_busy,
    output logic              o_we,
    output logic [AW-1:0]     o_waddr,
    output logic [DW-1:0]     o_wdata,
    output logic [DW/8-1:0]   o_wbe,
    output logic              o_pinj,
    output logic              o_rden
);
    import sram_pkg::*;

    localparam int            NB        = DW / 8;
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    state_e        r_state;
    logic [AW-1:0] r_cnt;

    // State and clear counter: one word per cycle while clearing; a request restarts the clear only from READY.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_INIT;
            r_cnt   <= {AW{1'b0}};
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + AW'(1'b1);
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= ST_READY;
                    end else begin
                        r_state <= ST_INIT;
                    end
                end
                ST_READY: begin
                    if (i_init_req) begin
                        r_state <= ST_INIT;
                        r_cnt   <= {AW{1'b0}};
                    end else begin
                        r_state <= ST_READY;
                        r_cnt   <= r_cnt;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= {AW{1'b0}};
                end
            endcase
        end
    end

    assign o_busy = (r_state == ST_INIT);

    // Write-port mux: the sequencer owns the array while clearing; otherwise the user port passes through.
    always_comb begin
        o_we    = 1'b0;
        o_waddr = {AW{1'b0}};
        o_wdata = {DW{1'b0}};
        o_wbe   = {NB{1'b0}};
        o_pinj  = 1'b0;
        o_rden  = 1'b0;
        if (r_state == ST_INIT) begin
            o_we    = 1'b1;
            o_waddr = r_cnt;
            o_wdata = INIT_VAL;
            o_wbe   = {NB{1'b1}};
            o_pinj  = 1'b0;
            o_rden  = 1'b0;
        end else begin
            o_we    = i_wren;
            o_waddr = i_waddr;
            o_wdata = i_wdata;
            o_wbe   = i_wbe;
            o_pinj  = i_pinj;
            o_rden  = i_rden;
        end
    end

endmodule

// File: rtl/sram_dp_init.sv
// Parametrised simple-dual-port synchronous SRAM.
// - Provides per-byte write enables.
// - The read port is registered and flags each read beat with RVALID.
// - A same-cycle read and write to one address is write-first.
// - The clear sequencer writes INIT_VAL to every word after reset or on INIT_REQ.
// Optional build macro: SRAM_PARITY_EN.
// - Stores one even-parity bit per byte.
// - PINJ corrupts the stored parity of the bytes being written.
// - PERR flags a mismatch on a read beat.
module sram_dp_init #(
    parameter int            DW       = 8,
    parameter int            AW       = 4,
    parameter logic [DW-1:0] INIT_VAL = {DW{1'b0}}
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              WREN,
    input  logic [AW-1:0]     WADDR,
    input  logic [DW-1:0]     WDATA,
    input  logic [DW/8-1:0]   WBE,
    input  logic              PINJ,
    input  logic              RDEN,
    input  logic [AW-1:0]     RADDR,
    output logic [DW-1:0]     RDATA,
    output logic              RVALID,
    input  logic              INIT_REQ,
    output logic              INIT_BUSY,
    output logic              PERR
);
    import sram_pkg::*;

    localparam int DEPTH = 2 ** AW;
    localparam int NB    = DW / 8;

    logic            w_busy;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [DW-1:0]   w_wdata;
    logic [NB-1:0]   w_wbe;
    logic            w_pinj;
    logic            w_rden;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [DW-1:0]   w_old;
    logic [NB-1:0]   w_byp;
    logic [DW-1:0]   w_rd_word;
    logic            w_perr;

    logic [DW-1:0]   r_rdata;
    logic            r_rvalid;
    logic            r_perr;

    sram_init_fsm #(
        .AW       (AW),
        .DW       (DW),
        .INIT_VAL (INIT_VAL)
    ) u_init_fsm (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .i_init_req (INIT_REQ),
        .i_wren     (WREN),
        .i_waddr    (WADDR),
        .i_wdata    (WDATA),
        .i_wbe      (WBE),
        .i_pinj     (PINJ),
        .i_rden     (RDEN),
        .o_busy     (w_busy),
        .o_we       (w_we),
        .o_waddr    (w_waddr),
        .o_wdata    (w_wdata),
        .o_wbe      (w_wbe),
        .o_pinj     (w_pinj),
        .o_rden     (w_rden)
    );

    // Data array write: only the enabled bytes change; the array itself is never reset.
    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_wbe[i]) begin
                    r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];

    // Parity array write: even parity per written byte, inverted when injection is requested.
    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_wbe[i]) begin
                    r_par[w_waddr][i] <= byte_parity(w_wdata[8*i +: 8]) ^ w_pinj;
                end
            end
        end
    end
`endif

    // Read path: write-first merge of same-address bytes, parity check only on bytes read from the array.
    always_comb begin
        w_old     = r_mem[RADDR];
        w_byp     = {NB{1'b0}};
        w_rd_word = {DW{1'b0}};
        w_perr    = 1'b0;
        for (int i = 0; i < NB; i++) begin
            w_byp[i] = w_we && w_wbe[i] && (w_waddr == RADDR);
            w_rd_word[8*i +: 8] = byte_merge(w_old[8*i +: 8], w_wdata[8*i +: 8], w_byp[i]);
`ifdef SRAM_PARITY_EN
            if (!w_byp[i] && (byte_parity(w_old[8*i +: 8]) != r_par[RADDR][i])) begin
                w_perr = 1'b1;
            end else begin
                w_perr = w_perr;
            end
`endif
        end
    end

`ifndef SRAM_PARITY_EN
    logic w_unused_pinj;
    assign w_unused_pinj = w_pinj;
`endif

    // Read register: RDATA loads on an accepted read and holds otherwise; RVALID and PERR pulse once per read.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rdata  <= {DW{1'b0}};
            r_rvalid <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_rvalid <= w_rden;
            r_perr   <= w_rden & w_perr;
            if (w_rden) begin
                r_rdata <= w_rd_word;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    assign RDATA     = r_rdata;
    assign RVALID    = r_rvalid;
    assign PERR      = r_perr;
    assign INIT_BUSY = w_busy;

endmodule

// File: tb/tb_sram_dp_init.sv
// Self-checking bench for sram_dp_init (DW=16, AW=4, INIT_VAL=0).
// Uses a word/byte-level reference model of memory contents and injected parity faults.
module tb_sram_dp_init;

    logic        CLK;
    logic        RST_N;
    logic        WREN;
    logic [3:0]  WADDR;
    logic [15:0] WDATA;
    logic [1:0]  WBE;
    logic        PINJ;
    logic        RDEN;
    logic [3:0]  RADDR;
    logic [15:0] RDATA;
    logic        RVALID;
    logic        INIT_REQ;
    logic        INIT_BUSY;
    logic        PERR;

`ifdef SRAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] m_mem [16];
    logic [1:0]  m_inj [16];
    logic [15:0] e_rdata;
    logic        e_valid;
    logic        e_perr;

    sram_dp_init #(
        .DW       (16),
        .AW       (4),
        .INIT_VAL (16'h0000)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .WREN      (WREN),
        .WADDR     (WADDR),
        .WDATA     (WDATA),
        .WBE       (WBE),
        .PINJ      (PINJ),
        .RDEN      (RDEN),
        .RADDR     (RADDR),
        .RDATA     (RDATA),
        .RVALID    (RVALID),
        .INIT_REQ  (INIT_REQ),
        .INIT_BUSY (INIT_BUSY),
        .PERR      (PERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        WREN = 1'b0; WADDR = 4'd0; WDATA = 16'h0000; WBE = 2'b00;
        PINJ = 1'b0; RDEN = 1'b0; RADDR = 4'd0; INIT_REQ = 1'b0;
    endtask

    task automatic model_clear();
        for (int a = 0; a < 16; a++) begin
            m_mem[a] = 16'h0000;
            m_inj[a] = 2'b00;
        end
    endtask

    // One ready-state cycle: drive, predict from the model, clock, leave the DUT ready to be sampled.
    task automatic tick(input logic wren, input logic [3:0] waddr, input logic [15:0] wdata,
                        input logic [1:0] wbe, input logic pinj, input logic rden,
                        input logic [3:0] raddr, input logic ireq);
        WREN = wren; WADDR = waddr; WDATA = wdata; WBE = wbe; PINJ = pinj;
        RDEN = rden; RADDR = raddr; INIT_REQ = ireq;
        e_perr = 1'b0;
        if (rden) begin
            e_valid = 1'b1;
            for (int b = 0; b < 2; b++) begin
                if (wren && wbe[b] && (waddr == raddr)) begin
                    e_rdata[8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    e_rdata[8*b +: 8] = m_mem[raddr][8*b +: 8];
                    if (PAR && m_inj[raddr][b]) e_perr = 1'b1;
                end
            end
        end else begin
            e_valid = 1'b0;
        end
        for (int b = 0; b < 2; b++) begin
            if (wren && wbe[b]) begin
                m_mem[waddr][8*b +: 8] = wdata[8*b +: 8];
                m_inj[waddr][b] = pinj;
            end
        end
        @(posedge CLK); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        tests_run++;
        if (RDATA !== 16'h0000) begin tests_failed++; $display("FAIL reset_rdata: got %h expected 0000", RDATA); end
        tests_run++;
        if (RVALID !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid: got %b expected 0", RVALID); end
        tests_run++;
        if (PERR !== 1'b0) begin tests_failed++; $display("FAIL reset_perr: got %b expected 0", PERR); end
        tests_run++;
        if (INIT_BUSY !== 1'b1) begin tests_failed++; $display("FAIL reset_busy: got %b expected 1", INIT_BUSY); end
        RST_N = 1'b1;
        begin
            int n = 0;
            while (INIT_BUSY === 1'b1 && n < 40) begin
                @(posedge CLK); #1; n++;
            end
            tests_run++;
            if (n != 16) begin tests_failed++; $display("FAIL reset_busy_len: got %0d cycles expected 16", n); end
        end
        model_clear();
        e_rdata = 16'h0000;
    endtask

    task automatic test_init_readback();
        for (int a = 0; a < 16; a++) begin
            tick(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 1'b1, a[3:0], 1'b0);
            tests_run++;
            if (RVALID !== 1'b1 || RDATA !== 16'h0000 || PERR !== 1'b0) begin
                tests_failed++;
                $display("FAIL init_read[%0d]: got v=%b d=%h p=%b expected v=1 d=0000 p=0", a, RVALID, RDATA, PERR);
            end
        end
        tick(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        tests_run++;
        if (RVALID !== 1'b0) begin tests_failed++; $display("FAIL rvalid_pulse: got %b expected 0", RVALID); end
    endtask

    task automatic test_byte_write();
        tick(1'b1, 4'd3, 16'hA55A, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        tick(1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 1'b0, 4'd0, 1'b0);
        tick(1'b1, 4'd4, 16'hFFFF, 2'b00, 1'b0, 1'b1, 4'd3, 1'b0);
        tests_run++;
        if (RDATA !== 16'hA534 || RVALID !== 1'b1) begin
            tests_failed++; $display("FAIL byte_write: got %h v=%b expected a534 v=1", RDATA, RVALID);
        end
        tick(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 1'b1, 4'd4, 1'b0);
        tests_run++;
        if (RDATA !== 16'h0000) begin tests_failed++; $display("FAIL wbe_zero: got %h expected 0000", RDATA); end
    endtask

    task automatic test_bypass();
        tick(1'b1, 4'd7, 16'hBEEF, 2'b10, 1'b0, 1'b1, 4'd7, 1'b0);
        tests_run++;
        if (RDATA !== 16'hBE00 || RVALID !== 1'b1 || PERR !== 1'b0) begin
            tests_failed++; $display("FAIL bypass: got d=%h v=%b p=%b expected d=be00 v=1 p=0", RDATA, RVALID, PERR);
        end
        tick(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        tests_run++;
        if (RDATA !== 16'hBE00 || RVALID !== 1'b0) begin
            tests_failed++; $display("FAIL rdata_hold: got d=%h v=%b expected d=be00 v=0", RDATA, RVALID);
        end
    endtask

    task automatic test_parity();
        tick(1'b1, 4'd2, 16'h00FF, 2'b11, 1'b1, 1'b0, 4'd0, 1'b0);
        tick(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 1'b1, 4'd2, 1'b0);
        tests_run++;
        if (PERR !== PAR || RDATA !== 16'h00FF) begin
            tests_failed++; $display("FAIL parity_inject: got p=%b d=%h expected p=%b d=00ff", PERR, RDATA, PAR);
        end
        tick(1'b1, 4'd2, 16'h00FF, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        tick(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 1'b1, 4'd2, 1'b0);
        tests_run++;
        if (PERR !== 1'b0) begin tests_failed++; $display("FAIL parity_clean: got %b expected 0", PERR); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            tick(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 2'($urandom),
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 4'($urandom), 1'b0);
            tests_run++;
            if (RVALID !== e_valid || RDATA !== e_rdata || PERR !== e_perr) begin
                tests_failed++;
                $display("FAIL random[%0d]: got v=%b d=%h p=%b expected v=%b d=%h p=%b",
                         c, RVALID, RDATA, PERR, e_valid, e_rdata, e_perr);
            end
        end
    endtask

    task automatic test_init_req();
        for (int a = 0; a < 16; a++) tick(1'b1, a[3:0], 16'($urandom) | 16'h0101, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        // Request cycle: the read and write issued alongside it still happen.
        tick(1'b1, 4'd5, 16'hC3C3, 2'b11, 1'b0, 1'b1, 4'd6, 1'b1);
        tests_run++;
        if (RVALID !== 1'b1 || RDATA !== e_rdata || INIT_BUSY !== 1'b1) begin
            tests_failed++; $display("FAIL init_req_cycle: got v=%b d=%h busy=%b expected v=1 d=%h busy=1",
                                     RVALID, RDATA, INIT_BUSY, e_rdata);
        end
        begin
            int n = 0;
            while (INIT_BUSY === 1'b1 && n < 40) begin
                WREN = 1'b1; WADDR = 4'($urandom); WDATA = 16'hFFFF; WBE = 2'b11;
                RDEN = 1'b1; RADDR = 4'($urandom); INIT_REQ = (n == 3);
                @(posedge CLK); #1; n++;
                idle_inputs();
                tests_run++;
                if (RVALID !== 1'b0 || RDATA !== e_rdata) begin
                    tests_failed++; $display("FAIL busy_lockout[%0d]: got v=%b d=%h expected v=0 d=%h", n, RVALID, RDATA, e_rdata);
                end
            end
            tests_run++;
            if (n != 16) begin tests_failed++; $display("FAIL init_req_len: got %0d cycles expected 16", n); end
        end
        model_clear();
        for (int a = 0; a < 16; a++) begin
            tick(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 1'b1, a[3:0], 1'b0);
            tests_run++;
            if (RDATA !== 16'h0000 || RVALID !== 1'b1 || PERR !== 1'b0) begin
                tests_failed++; $display("FAIL reinit_read[%0d]: got d=%h v=%b p=%b expected d=0000 v=1 p=0", a, RDATA, RVALID, PERR);
            end
        end
    endtask

    task automatic test_reset_mid_init();
        tick(1'b1, 4'd9, 16'h5AA5, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0);
        tick(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 1'b1, 4'd9, 1'b1);
        repeat (5) begin @(posedge CLK); #1; end
        tests_run++;
        if (RDATA !== 16'h5AA5 || INIT_BUSY !== 1'b1) begin
            tests_failed++; $display("FAIL mid_init_hold: got d=%h busy=%b expected d=5aa5 busy=1", RDATA, INIT_BUSY);
        end
        RST_N = 1'b0;
        #2;
        tests_run++;
        if (RDATA !== 16'h0000 || RVALID !== 1'b0 || PERR !== 1'b0 || INIT_BUSY !== 1'b1) begin
            tests_failed++; $display("FAIL mid_init_reset: got d=%h v=%b p=%b busy=%b expected d=0000 v=0 p=0 busy=1",
                                     RDATA, RVALID, PERR, INIT_BUSY);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        begin
            int n = 0;
            while (INIT_BUSY === 1'b1 && n < 40) begin
                @(posedge CLK); #1; n++;
            end
            tests_run++;
            if (n != 16) begin tests_failed++; $display("FAIL mid_init_len: got %0d cycles expected 16", n); end
        end
        model_clear();
        e_rdata = 16'h0000;
        tick(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 1'b1, 4'd9, 1'b0);
        tests_run++;
        if (RDATA !== 16'h0000 || RVALID !== 1'b1) begin
            tests_failed++; $display("FAIL mid_init_clear: got d=%h v=%b expected d=0000 v=1", RDATA, RVALID);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        idle_inputs();
        e_rdata = 16'h0000;
        e_valid = 1'b0;
        e_perr  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        test_init_readback();
        test_byte_write();
        test_bypass();
        test_parity();
        test_random();
        test_init_req();
        test_reset_mid_init();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
